spi_mem_ctrl: RTL and testbench

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

---
 rtl/spi_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master bridging single CPU memory requests to a flash or RAM device.
// Define SPI_MEM_WRITE_EN to build the write datapath; without it writes are rejected with rsp_err.
module spi_mem_ctrl #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_sel,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_flash,
  output logic              cs_ram,
  input  logic              miso,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse with no back-pressure.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int HW    = 8 + ADDR_W;
  localparam int CNT_W = $clog2(ADDR_W + 33);

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [HW-1:0]    hdr_sh;
  logic [31:0]      rx_sh;
  logic [1:0]       size_q;
  logic             req_illegal;
  logic             data_rd;
  logic [7:0]       cmd;

`ifdef SPI_MEM_WRITE_EN
  logic             wr_q;
  logic [31:0]      wd_sh;
  assign req_illegal = (req_size == 2'd3);
  assign data_rd     = ~wr_q;
  assign cmd         = req_write ? 8'h02 : 8'h03;
`else
  logic             unused_wdata;
  assign unused_wdata = ^req_wdata;
  assign req_illegal  = (req_size == 2'd3) | req_write;
  assign data_rd      = 1'b1;
  assign cmd          = 8'h03;
`endif

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // hdr_sh holds the frame bits still to be sent after the one currently on mosi.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      hdr_sh    <= '0;
      rx_sh     <= '0;
      size_q    <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_flash  <= 1'b1;
      cs_ram    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef SPI_MEM_WRITE_EN
      wr_q      <= 1'b0;
      wd_sh     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            size_q <= req_size;
            if (req_illegal) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state    <= S_CMD;
              cs_flash <= req_sel;
              cs_ram   <= ~req_sel;
              sclk     <= 1'b0;
              mosi     <= cmd[7];
              hdr_sh   <= {cmd[6:0], req_addr, 1'b0};
              bit_cnt  <= CNT_W'(7);
`ifdef SPI_MEM_WRITE_EN
              wr_q     <= req_write;
              // Byte 0 goes out first, so pack the bytes big-endian for an MSB shift.
              wd_sh    <= {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
`endif
            end
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (!sclk) begin
            sclk <= 1'b1;
            if (state == S_DATA && data_rd) begin
              rx_sh <= {rx_sh[30:0], miso};
            end
          end else begin
            sclk <= 1'b0;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              if (state == S_DATA) begin
`ifdef SPI_MEM_WRITE_EN
                mosi  <= wr_q ? wd_sh[31] : 1'b0;
                wd_sh <= {wd_sh[30:0], 1'b0};
`else
                mosi  <= 1'b0;
`endif
              end else begin
                mosi   <= hdr_sh[HW-1];
                hdr_sh <= {hdr_sh[HW-2:0], 1'b0};
              end
            end else if (state == S_CMD) begin
              state   <= S_ADDR;
              bit_cnt <= CNT_W'(ADDR_W - 1);
              mosi    <= hdr_sh[HW-1];
              hdr_sh  <= {hdr_sh[HW-2:0], 1'b0};
            end else if (state == S_ADDR) begin
              state <= S_DATA;
              case (size_q)
                2'd0:    bit_cnt <= CNT_W'(7);
                2'd1:    bit_cnt <= CNT_W'(15);
                default: bit_cnt <= CNT_W'(31);
              endcase
`ifdef SPI_MEM_WRITE_EN
              mosi  <= wr_q ? wd_sh[31] : 1'b0;
              wd_sh <= {wd_sh[30:0], 1'b0};
`else
              mosi  <= 1'b0;
`endif
            end else begin
              state     <= S_DONE;
              mosi      <= 1'b0;
              cs_flash  <= 1'b1;
              cs_ram    <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              // The first received byte sits highest in rx_sh; reverse into ascending address order.
              if (data_rd) begin
                case (size_q)
                  2'd0:    rsp_rdata <= {24'h0, rx_sh[7:0]};
                  2'd1:    rsp_rdata <= {16'h0, rx_sh[7:0], rx_sh[15:8]};
                  default: rsp_rdata <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
                endcase
              end
            end
          end
        end

        S_DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: directed and random requests against a frame-level SPI slave model,
// with a scoreboard queue of expected responses checked by an independent monitor.
module tb_spi_mem_ctrl;

  localparam int ADDR_W = 24;
  localparam int FM     = 8 + ADDR_W + 32;
`ifdef SPI_MEM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_sel;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              sclk;
  logic              mosi;
  logic              cs_flash;
  logic              cs_ram;
  logic              miso;
  logic [2:0]        dbg_state;

  spi_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sclk(sclk), .mosi(mosi), .cs_flash(cs_flash), .cs_ram(cs_ram), .miso(miso),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    logic          is_read;
    int            lat;
    int            acc;
    int            nbits;
    logic [FM-1:0] frame;
    logic [1:0]    cs_exp;
    logic [31:0]   mw;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_err = 0;
  int idle_viol = 0;
  int hold_viol = 0;
  logic [31:0]   last_rd = '0;
  logic [FM-1:0] cap = '0;
  int            cap_n = 0;
  bit            seen_f = 0;
  bit            seen_r = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a request should produce, from the frame format and latency rule.
  function automatic exp_t model(input bit wr, input bit sel, input logic [1:0] size,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                                 input logic [31:0] mw);
    exp_t r;
    int n;
    int p;
    logic [7:0] cmd;
    logic [7:0] b;
    bit legal;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    legal     = (size != 2'd3) && (!wr || WR_EN);
    r.err     = !legal;
    r.is_read = legal && !wr;
    r.frame   = '0;
    r.nbits   = 0;
    r.lat     = 1;
    r.cs_exp  = 2'b00;
    r.mw      = mw;
    r.acc     = 0;
    r.rdata   = '0;
    if (legal) begin
      r.nbits  = 8 + ADDR_W + 8 * n;
      r.lat    = 2 * r.nbits + 1;
      r.cs_exp = sel ? 2'b01 : 2'b10;
      cmd = wr ? 8'h02 : 8'h03;
      p = 0;
      for (int i = 7; i >= 0; i--) begin r.frame[FM-1-p] = cmd[i]; p++; end
      for (int i = ADDR_W - 1; i >= 0; i--) begin r.frame[FM-1-p] = addr[i]; p++; end
      for (int j = 0; j < n; j++) begin
        b = wr ? wd[8*j +: 8] : 8'h00;
        for (int i = 7; i >= 0; i--) begin r.frame[FM-1-p] = b[i]; p++; end
        if (!wr) r.rdata[8*j +: 8] = mw[8*j +: 8];
      end
    end
    return r;
  endfunction

  // SPI slave: records mosi during high phases, drives miso during low phases.
  always @(negedge clk) begin
    int k;
    if (cs_flash === 1'b0 || cs_ram === 1'b0) begin
      if (cs_flash === 1'b0) seen_f = 1;
      if (cs_ram === 1'b0) seen_r = 1;
      if (sclk === 1'b1) begin
        if (cap_n < FM) cap[FM-1-cap_n] = mosi;
        cap_n++;
      end else begin
        k = cap_n - (8 + ADDR_W);
        if (k >= 0 && k < 32 && exp_q.size() > 0) miso = exp_q[0].mw[8*(k/8) + 7 - (k%8)];
        else miso = 1'($urandom);
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cs_flash === 1'b1 && cs_ram === 1'b1 && (sclk !== 1'b0 || mosi !== 1'b0)) idle_viol++;
      if (rsp_valid !== 1'b1 && rsp_rdata !== last_rd) hold_viol++;
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_err", rsp_err, mon_e.err);
          chk("rsp_rdata", rsp_rdata, mon_e.is_read ? mon_e.rdata : last_rd);
          chk("latency", cyc - mon_e.acc, mon_e.lat);
          chk("frame_bits", cap_n, mon_e.nbits);
          chk("mosi_frame", cap, mon_e.frame);
          chk("cs_select", {seen_f, seen_r}, mon_e.cs_exp);
          if (mon_e.is_read) last_rd = mon_e.rdata;
        end
        cap = '0; cap_n = 0; seen_f = 0; seen_r = 0;
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic issue(input bit wr, input bit sel, input logic [1:0] size,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] mw, input bit hold);
    exp_t e;
    bit done;
    done = 0;
    req_valid = 1'b1; req_write = wr; req_sel = sel; req_size = size;
    req_addr = addr; req_wdata = wd;
    for (int t = 0; t < 400 && !done; t++) begin
      if (req_ready === 1'b1) begin
        e = model(wr, sel, size, addr, wd, mw);
        e.acc = cyc;
        exp_q.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) chk("accept_timeout", 0, 1);
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom); req_sel = 1'($urandom); req_size = 2'($urandom);
      req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int t = 0; t < 600 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready === 1'b1) ok = 1;
    end
    if (!ok) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    bit hold;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_sel = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_flash", cs_flash, 1);
    chk("rst_cs_ram", cs_ram, 1);
    rst = 1'b0;
    @(negedge clk);

    // flash read of 4 bytes, slave returns EF BE AD DE
    issue(0, 0, 2'd2, 24'h000010, 32'h0, 32'hDEADBEEF, 0);
    wait_done();
    // RAM write of 2 bytes (rejected when the write path is not built)
    issue(1, 1, 2'd1, 24'h000100, 32'h0000A55A, 32'h0, 0);
    wait_done();
    // single-byte read with req_valid held, then a second request queued behind it
    issue(0, 0, 2'd0, 24'h000200, 32'h0, 32'h1234567F, 1);
    chk("ready_busy", req_ready, 0);
    issue(0, 1, 2'd1, 24'h000300, 32'h0, 32'hCAFE5AA5, 0);
    wait_done();
    // illegal size, and a 4-byte write
    issue(0, 0, 2'd3, 24'h000400, 32'h0, 32'h0, 0);
    wait_done();
    issue(1, 1, 2'd3, 24'h000404, 32'h11223344, 32'h0, 0);
    wait_done();
    issue(1, 0, 2'd2, 24'h000408, 32'h89ABCDEF, 32'h0, 0);
    wait_done();

    // reset in the middle of the address phase, with a competing request
    issue(0, 0, 2'd2, 24'hABCDEF, 32'h0, 32'h55AA33CC, 0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_sel = 1'b1; req_size = 2'd0;
    @(negedge clk);
    chk("abort_cs_flash", cs_flash, 1);
    chk("abort_cs_ram", cs_ram, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    cap = '0; cap_n = 0; seen_f = 0; seen_r = 0;
    last_rd = '0;
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(0, 0, 2'd2, 24'h000020, 32'h0, 32'h0BADF00D, 0);
    wait_done();

    // random traffic
    for (int i = 0; i < 24; i++) begin
      hold = (i < 23) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ADDR_W'($urandom), $urandom, $urandom, hold);
      if (!hold) wait_done();
    end
    wait_done();

    chk("idle_pins", idle_viol, 0);
    chk("rdata_hold", hold_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
